// File: rtl/mem_access_ctrl_if.sv
// Request/response and RAM-side bus of the memory access sequencer.
// slave is the sequencer's view; master is the control-unit/RAM environment view.
interface mem_access_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [DATA_WIDTH-1:0] resp_rdata;
   logic                  resp_err;
   logic                  ram_read;
   logic                  ram_write;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [DATA_WIDTH-1:0] ram_rdata;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready, ram_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output ram_read, ram_write, ram_addr, ram_wdata
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready, ram_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  ram_read, ram_write, ram_addr, ram_wdata
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// MAR/MDR sequencer in front of the main-memory RAM: one load/store at a time, fixed strobe length.
// Optional macro MEM_BOUNDS_CHECK_EN answers out-of-range addresses with resp_err instead of a RAM access.
module mem_access_ctrl #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int MEM_DEPTH   = 512,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                     clock,
   input  logic                     reset_n,
   mem_access_ctrl_if.slave         bus,
   output logic                     busy
);
   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t                state_r;
   state_t                state_next_s;
   logic [CW-1:0]         count_r;
   logic [ADDR_WIDTH-1:0] mar_r;
   logic [DATA_WIDTH-1:0] mdr_r;
   logic                  op_write_r;
   logic                  err_r;
   logic                  oob_s;

`ifdef MEM_BOUNDS_CHECK_EN
   assign oob_s = (bus.req_addr >= ADDR_WIDTH'(MEM_DEPTH));
`else
   assign oob_s = 1'b0;
`endif

   // State register
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.req_valid) begin
               state_next_s = oob_s ? RESP : ACCESS;
            end else begin
               state_next_s = IDLE;
            end
         end
         ACCESS: begin
            if (count_r == CW'(0)) begin
               state_next_s = CAPTURE;
            end else begin
               state_next_s = ACCESS;
            end
         end
         CAPTURE: state_next_s = RESP;
         RESP: begin
            if (bus.resp_ready) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = RESP;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // MAR/MDR, operation, wait counter and error flag
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         count_r    <= CW'(0);
         mar_r      <= {ADDR_WIDTH{1'b0}};
         mdr_r      <= {DATA_WIDTH{1'b0}};
         op_write_r <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.req_valid) begin
                  mar_r      <= bus.req_addr;
                  op_write_r <= bus.req_write;
                  count_r    <= CW'(WAIT_CYCLES - 1);
                  // Rejected requests carry no data into the response.
                  mdr_r      <= oob_s ? {DATA_WIDTH{1'b0}} : bus.req_wdata;
                  err_r      <= oob_s;
               end
            end
            ACCESS: begin
               if (count_r != CW'(0)) begin
                  count_r <= count_r - CW'(1);
               end
            end
            CAPTURE: begin
               mdr_r <= op_write_r ? {DATA_WIDTH{1'b0}} : bus.ram_rdata;
            end
            RESP: begin
               if (bus.resp_ready) begin
                  err_r <= 1'b0;
               end
            end
            default: begin
               count_r <= CW'(0);
            end
         endcase
      end
   end

   // Output decode from the registered state
   always_comb begin
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_rdata = {DATA_WIDTH{1'b0}};
      bus.resp_err   = 1'b0;
      bus.ram_read   = 1'b0;
      bus.ram_write  = 1'b0;
      bus.ram_addr   = {ADDR_WIDTH{1'b0}};
      bus.ram_wdata  = {DATA_WIDTH{1'b0}};
      busy           = 1'b1;
      case (state_r)
         IDLE: begin
            bus.req_ready = 1'b1;
            busy          = 1'b0;
         end
         ACCESS: begin
            bus.ram_read  = ~op_write_r;
            bus.ram_write = op_write_r;
            bus.ram_addr  = mar_r;
            bus.ram_wdata = mdr_r;
         end
         CAPTURE: busy = 1'b1;
         RESP: begin
            bus.resp_valid = 1'b1;
            bus.resp_rdata = mdr_r;
            bus.resp_err   = err_r;
         end
         default: busy = 1'b1;
      endcase
   end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a negedge-sampling RAM model.
module tb_mem_access_ctrl;
   logic clk = 1'b0;
   logic reset_n;
   logic busy;
   int   errors = 0;
   int   checks = 0;

   mem_access_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

   mem_access_ctrl dut (
      .clock   (clk),
      .reset_n (reset_n),
      .bus     (bus.slave),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:1023];
   logic [31:0] ram_q = 32'd0;
   assign bus.ram_rdata = ram_q;

   always @(negedge clk) begin
      if (bus.ram_write) mem[bus.ram_addr[9:0]] <= bus.ram_wdata;
      if (bus.ram_read)  ram_q <= mem[bus.ram_addr[9:0]];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one request, then watches up to 8 cycles until resp_valid.
   task automatic do_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output int rd_cnt, output int wr_cnt, output int first_resp,
                            output int bus_bad);
      rd_cnt = 0; wr_cnt = 0; first_resp = -1; bus_bad = 0;
      bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr; bus.req_wdata = wdata;
      tick();
      bus.req_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (bus.ram_read) rd_cnt++;
         if (bus.ram_write) wr_cnt++;
         if (bus.ram_read && bus.ram_write) bus_bad++;
         if ((bus.ram_read || bus.ram_write) &&
             (bus.ram_addr !== addr || (wr && bus.ram_wdata !== wdata))) bus_bad++;
         if (bus.resp_valid) begin
            first_resp = i;
            break;
         end
         tick();
      end
   endtask

   task automatic finish_resp();
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; bus.req_valid = 1'b1;
      repeat (3) tick();
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if ({bus.ram_read, bus.ram_write} !== 2'b00) begin errors++; $display("FAIL reset_strobes got=%b exp=00", {bus.ram_read, bus.ram_write}); end
      checks++; if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp got=%b%b exp=00", bus.resp_valid, bus.resp_err); end
      bus.req_valid = 1'b0; reset_n = 1'b1;
      tick();
   endtask

   task automatic test_store();
      int rd, wr, first, bad;
      do_access(1'b1, 32'd90, 32'd85, rd, wr, first, bad);
      checks++; if (wr !== 2 || rd !== 0) begin errors++; $display("FAIL store_strobes got wr=%0d rd=%0d exp wr=2 rd=0", wr, rd); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL store_bus got=%0d bad cycles exp=0", bad); end
      checks++; if (first !== 3) begin errors++; $display("FAIL store_latency got=%0d exp=3", first); end
      checks++; if (bus.resp_rdata !== 32'd0 || bus.resp_err !== 1'b0) begin errors++; $display("FAIL store_resp got=%0d err=%b exp=0 err=0", bus.resp_rdata, bus.resp_err); end
      checks++; if (mem[90] !== 32'd85) begin errors++; $display("FAIL store_ram got=%0d exp=85", mem[90]); end
      finish_resp();
      checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL store_done got v=%b r=%b exp v=0 r=1", bus.resp_valid, bus.req_ready); end
   endtask

   task automatic test_load();
      int rd, wr, first, bad;
      do_access(1'b0, 32'd133, 32'hDEAD_BEEF, rd, wr, first, bad);
      checks++; if (rd !== 2 || wr !== 0) begin errors++; $display("FAIL load_strobes got rd=%0d wr=%0d exp rd=2 wr=0", rd, wr); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL load_bus got=%0d bad cycles exp=0", bad); end
      checks++; if (first !== 3) begin errors++; $display("FAIL load_latency got=%0d exp=3", first); end
      checks++; if (bus.resp_rdata !== 32'd16 || bus.resp_err !== 1'b0) begin errors++; $display("FAIL load_data got=%0d err=%b exp=16 err=0", bus.resp_rdata, bus.resp_err); end
      finish_resp();
   endtask

   task automatic test_backpressure();
      int rd, wr, first, bad, held_bad;
      held_bad = 0;
      do_access(1'b0, 32'd5, 32'd0, rd, wr, first, bad);
      checks++; if (first !== 3 || bus.resp_rdata !== 32'hA5A5_0005) begin errors++; $display("FAIL bp_first got lat=%0d data=%h exp lat=3 data=a5a50005", first, bus.resp_rdata); end
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'd7;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hA5A5_0005 || bus.req_ready !== 1'b0 ||
             bus.ram_read !== 1'b0 || bus.ram_write !== 1'b0) held_bad++;
      end
      checks++; if (held_bad !== 0) begin errors++; $display("FAIL bp_hold got=%0d bad cycles exp=0", held_bad); end
      finish_resp();
      checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got r=%b v=%b exp r=1 v=0", bus.req_ready, bus.resp_valid); end
      tick();
      bus.req_valid = 1'b0;
      checks++; if (bus.ram_read !== 1'b1 || bus.ram_addr !== 32'd7) begin errors++; $display("FAIL bp_next got rd=%b addr=%0d exp rd=1 addr=7", bus.ram_read, bus.ram_addr); end
      repeat (3) tick();
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'd1234) begin errors++; $display("FAIL bp_next_resp got v=%b data=%0d exp v=1 data=1234", bus.resp_valid, bus.resp_rdata); end
      finish_resp();
   endtask

   task automatic test_reset_mid();
      int seen;
      seen = 0;
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'd133;
      tick();
      bus.req_valid = 1'b0;
      checks++; if (bus.ram_read !== 1'b1) begin errors++; $display("FAIL mid_access got rd=%b exp=1", bus.ram_read); end
      reset_n = 1'b0;
      tick();
      checks++; if ({bus.ram_read, bus.ram_write, busy, bus.req_ready} !== 4'b0001) begin errors++; $display("FAIL mid_abort got=%b exp=0001", {bus.ram_read, bus.ram_write, busy, bus.req_ready}); end
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.resp_valid) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_resp got=%0d exp=0", seen); end
   endtask

   task automatic test_bounds();
      int rd, wr, first, bad;
      do_access(1'b0, 32'd600, 32'd0, rd, wr, first, bad);
`ifdef MEM_BOUNDS_CHECK_EN
      checks++; if (rd !== 0 || wr !== 0) begin errors++; $display("FAIL bounds_strobes got rd=%0d wr=%0d exp 0 0", rd, wr); end
      checks++; if (first !== 0 || bus.resp_err !== 1'b1 || bus.resp_rdata !== 32'd0) begin errors++; $display("FAIL bounds_resp got lat=%0d err=%b data=%0d exp 0 1 0", first, bus.resp_err, bus.resp_rdata); end
      finish_resp();
      checks++; if (bus.resp_err !== 1'b0) begin errors++; $display("FAIL bounds_clear got=%b exp=0", bus.resp_err); end
`else
      checks++; if (rd !== 2 || wr !== 0 || bad !== 0) begin errors++; $display("FAIL bounds_strobes got rd=%0d wr=%0d bad=%0d exp 2 0 0", rd, wr, bad); end
      checks++; if (first !== 3 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'd77) begin errors++; $display("FAIL bounds_resp got lat=%0d err=%b data=%0d exp 3 0 77", first, bus.resp_err, bus.resp_rdata); end
      finish_resp();
`endif
   endtask

   task automatic test_back_to_back();
      int accepts, resps, both;
      accepts = 0; resps = 0; both = 0;
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'd200; bus.req_wdata = 32'd1;
      bus.resp_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (bus.req_ready) accepts++;
         if (bus.resp_valid) resps++;
         if (bus.ram_read && bus.ram_write) both++;
         tick();
      end
      bus.req_valid = 1'b0; bus.resp_ready = 1'b0;
      checks++; if (accepts !== 2 || resps !== 2) begin errors++; $display("FAIL b2b_rate got acc=%0d resp=%0d exp 2 2", accepts, resps); end
      checks++; if (both !== 0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_end got both=%0d ready=%b exp 0 1", both, bus.req_ready); end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
      mem[133] = 32'd16;
      mem[5]   = 32'hA5A5_0005;
      mem[7]   = 32'd1234;
      mem[600] = 32'd77;
      reset_n = 1'b0;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 32'd0;
      bus.req_wdata = 32'd0; bus.resp_ready = 1'b0;
      test_reset();
      test_store();
      test_load();
      test_backpressure();
      test_reset_mid();
      test_bounds();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
